// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle WIDTH-bit adder built on a single 4-bit carry-lookahead slice
//
// cla4: combinational 4-bit carry-lookahead adder slice.
//   a_i, b_i  : 4-bit operands
//   cin_i     : carry in
//   s_o       : 4-bit sum
//   cout_o    : carry out of bit 3
//
// cla_seq_adder: adds one operand nibble per clock, LSB nibble first.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request, sampled only in IDLE or DONE
//   a, b, cin : operands and carry-in, captured on an accepted start
//   busy      : high while the nibble loop is running
//   done      : one-cycle pulse when sum/cout become valid
//   sum, cout : registered result, held until the next completion or reset
//   ovf       : signed overflow, present only when CLA_SEQ_OVF_EN is defined
//
// Optional feature macro: CLA_SEQ_OVF_EN (adds the ovf port and its logic).

module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Every carry is formed directly from generate/propagate terms, no ripple.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  // Holds the NIB-1 nibbles already produced; the last one goes straight to sum.
  logic [WIDTH-5:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       slice_s;
  logic             slice_c;
  logic             last_nib;

  cla4 u_cla4 (
    .a_i    (shift_a_q[3:0]),
    .b_i    (shift_b_q[3:0]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_c)
  );

  assign last_nib = (cnt_q == CW'(NIB - 1));

  // Shift the new nibble in at the top so the LSB nibble ends at the bottom.
  logic [WIDTH-5:0] psum_shift;
  generate
    if (NIB == 2) begin : g_psum_one
      assign psum_shift = slice_s;
    end else begin : g_psum_many
      assign psum_shift = {slice_s, psum_q[WIDTH-5:4]};
    end
  endgenerate

`ifdef CLA_SEQ_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    psum_d    = psum_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef CLA_SEQ_OVF_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          cnt_d     = '0;
          state_d   = S_RUN;
`ifdef CLA_SEQ_OVF_EN
          // Operands may change during RUN, so keep their sign bits here.
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        shift_a_d = shift_a_q >> 4;
        shift_b_d = shift_b_q >> 4;
        psum_d    = psum_shift;
        carry_d   = slice_c;
        cnt_d     = cnt_q + CW'(1);
        if (last_nib) begin
          sum_d   = {slice_s, psum_q};
          cout_d  = slice_c;
          state_d = S_DONE;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (slice_s[3] != a_msb_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      psum_q    <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      psum_q    <= psum_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
`ifdef CLA_SEQ_OVF_EN
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - self-checking bench for cla_seq_adder (WIDTH=16)

module tb_cla_seq_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain (W+1)-bit unsigned addition.
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Issues one add, scrambles the inputs during RUN, and returns how many busy
  // cycles were seen and how many edges after acceptance done appeared.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output int nb, output int lat);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    nb = 0;
    lat = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t       tbl[7];
  int         nb, lat;
  logic [W:0] exp_r;
  logic [W-1:0] ra, rb;
  logic       rc;
  logic       seen_done;

  initial begin
    tbl[0] = '{16'h0003, 16'h0007, 1'b0, 16'h000A, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
`ifdef CLA_SEQ_OVF_EN
    check("reset_ovf",  32'(ovf),  32'd0);
`endif

    for (int i = 0; i < 7; i++) begin
      run_add(tbl[i].a, tbl[i].b, tbl[i].cin, nb, lat);
      check($sformatf("tbl%0d_busy_cycles", i), 32'(nb), 32'(NIB));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(NIB));
      check($sformatf("tbl%0d_sum", i), 32'(sum), 32'(tbl[i].s));
      check($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].co));
`ifdef CLA_SEQ_OVF_EN
      check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
`endif
      @(negedge clk);
      check($sformatf("tbl%0d_done_single", i), 32'(done), 32'd0);
    end

    // Result must be held with no done while idle.
    run_add(16'h0003, 16'h0007, 1'b0, nb, lat);
    check("hold_first_sum", 32'(sum), 32'h000A);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0 && done) seen_done = 1'b1;
      if (sum !== 16'h000A) begin
        check("hold_sum", 32'(sum), 32'h000A);
      end
    end
    check("hold_no_done", 32'(seen_done), 32'd0);
    check("hold_sum_end", 32'(sum), 32'h000A);

    // Reset on the second RUN cycle aborts the add.
    @(negedge clk);
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = '1; rb = '0; rc = 1'b1; end
      exp_r = model_add(ra, rb, rc);
      run_add(ra, rb, rc, nb, lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(NIB));
      check($sformatf("rnd%0d_sum", i), 32'(sum), 32'(exp_r[W-1:0]));
      check($sformatf("rnd%0d_cout", i), 32'(cout), 32'(exp_r[W]));
`ifdef CLA_SEQ_OVF_EN
      check($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(model_ovf(ra, rb, exp_r[W-1:0])));
`endif
    end

    // start held high with new operands every cycle: only accepted values count.
    begin
      logic [W:0]   expq[$];
      logic [W-1:0] aq[$], bq[$];
      int last_done = -1;
      int ndone = 0;
      @(negedge clk);
      for (int c = 0; c < 32; c++) begin
        if (c > 0) @(negedge clk);
        if (done) begin
          ndone++;
          if (expq.size() == 0) begin
            check("b2b_unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_r = expq.pop_front();
            ra = aq.pop_front();
            rb = bq.pop_front();
            check($sformatf("b2b%0d_sum", ndone), 32'(sum), 32'(exp_r[W-1:0]));
            check($sformatf("b2b%0d_cout", ndone), 32'(cout), 32'(exp_r[W]));
`ifdef CLA_SEQ_OVF_EN
            check($sformatf("b2b%0d_ovf", ndone), 32'(ovf),
                  32'(model_ovf(ra, rb, exp_r[W-1:0])));
`endif
          end
          if (last_done >= 0) check($sformatf("b2b%0d_period", ndone), 32'(c - last_done), 32'(NIB + 1));
          last_done = c;
        end
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        if (!busy) begin
          expq.push_back(model_add(a, b, cin));
          aq.push_back(a);
          bq.push_back(b);
        end
      end
      start = 1'b0;
      check("b2b_done_count", 32'(ndone >= 5), 32'd1);
      repeat (8) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

endmodule
